mem_port_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store data port. Each cycle it grants at most one requester, drives the RAM, and returns read data to the owning requester after the fixed RAM read latency. It sits between the core and the unified program/data memory.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/rr_arb2.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 83 ++++++++
 tb/tb_mem_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   owner_t  : which requester owns a granted access / in-flight response
//   resp_t   : one response-tracking stage {valid, owner}
//   DEF_*    : default address/data width and RAM read latency
//   WR_EN_W  : byte write-enable width
package mem_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } resp_t;

    localparam int unsigned DEF_AW     = 32;
    localparam int unsigned DEF_DW     = 32;
    localparam int unsigned DEF_RD_LAT = 1;
    localparam int unsigned WR_EN_W    = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the RAM port of the
// arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            responses and the RAM command)
//   master : core + RAM view (the opposite directions)
interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    // fetch port
    logic               inst_req;
    logic [AW-1:0]      inst_addr;
    logic               inst_gnt;
    logic               inst_rvalid;
    logic [DW-1:0]      inst_rdata;
    // load/store port
    logic               data_req;
    logic [AW-1:0]      data_addr;
    logic [WR_EN_W-1:0] data_wr_en;
    logic [DW-1:0]      data_wr;
    logic               data_gnt;
    logic               data_rvalid;
    logic [DW-1:0]      data_rdata;
    // RAM port
    logic               mem_en;
    logic [AW-1:0]      mem_addr;
    logic [WR_EN_W-1:0] mem_wr_en;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_addr, data_wr_en, data_wr,
        input  mem_rdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output mem_en, mem_addr, mem_wr_en, mem_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_addr, data_wr_en, data_wr,
        output mem_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  mem_en, mem_addr, mem_wr_en, mem_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a one-hot, combinational grant.
//   clk, rst : clock, asynchronous active-high reset
//   i_req    : [0] fetch request, [1] data request
//   o_gnt    : one-hot grant, same bit order as i_req; forced to 0 in reset
// On a conflict the requester not granted most recently wins; after reset
// the most recent owner is DATA, so fetch wins the first conflict.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    owner_t     r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = '0;
        if (!rst) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last == OWN_DATA) ? 2'b01 : 2'b10;
                default: w_gnt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= OWN_DATA;
        end else if (w_gnt[0]) begin
            r_last <= OWN_INST;
        end else if (w_gnt[1]) begin
            r_last <= OWN_DATA;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the load/store port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch port, load/store port and RAM port (slave modport)
// Parameters: AW/DW bus widths, RD_LAT RAM read latency (1..4 cycles).
// Grants are combinational; each granted read is tracked through an
// RD_LAT-deep {valid, owner} shift register so its response is steered to
// the right port exactly RD_LAT cycles after the grant.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic [AW-1:0]      w_mem_addr;
    logic [DW-1:0]      w_mem_wdata;
    logic [WR_EN_W-1:0] w_mem_wr_en;
    resp_t              w_push;
    resp_t              r_pipe [RD_LAT];
    resp_t              w_head;

    assign w_req = {bus.data_req, bus.inst_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    // Command mux; a data grant with any byte enable set is a store and
    // produces no response.
    always_comb begin
        w_mem_addr   = bus.inst_addr;
        w_mem_wdata  = bus.data_wr;
        w_mem_wr_en  = '0;
        w_push       = '0;
        if (w_gnt[1]) begin
            w_mem_addr   = bus.data_addr;
            w_mem_wr_en  = bus.data_wr_en;
            w_push.valid = (bus.data_wr_en == '0);
            w_push.owner = OWN_DATA;
        end else if (w_gnt[0]) begin
            w_push.valid = 1'b1;
            w_push.owner = OWN_INST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_push;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_head = r_pipe[RD_LAT-1];

    assign bus.inst_gnt    = w_gnt[0];
    assign bus.data_gnt    = w_gnt[1];
    assign bus.mem_en      = |w_gnt;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wr_en   = w_mem_wr_en;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.inst_rvalid = w_head.valid && (w_head.owner == OWN_INST);
    assign bus.data_rvalid = w_head.valid && (w_head.owner == OWN_DATA);
    assign bus.inst_rdata  = bus.mem_rdata;
    assign bus.data_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Four arbiters with RD_LAT = 1..4 driven by one shared stimulus, each with
// its own RAM model (word i initialised to 0xA000_0000 | i).
module tb_mem_port_arbiter;

    logic        clk;
    logic        r_rst;
    logic        r_inst_req;
    logic [31:0] r_inst_addr;
    logic        r_data_req;
    logic [31:0] r_data_addr;
    logic [3:0]  r_data_wr_en;
    logic [31:0] r_data_wr;

    logic [3:0]  w_inst_gnt;
    logic [3:0]  w_data_gnt;
    logic [3:0]  w_inst_rvalid;
    logic [3:0]  w_data_rvalid;
    logic [3:0]  w_mem_en;
    logic [3:0]  w_mem_wr_en [4];
    logic [31:0] w_inst_rdata [4];
    logic [31:0] w_data_rdata [4];

    int checks;
    int failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : g_lat
        localparam int unsigned LAT = g + 1;

        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

        logic [31:0] ram  [256];
        logic [31:0] pipe [4];

        mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) u_dut (
            .clk (clk),
            .rst (r_rst),
            .bus (bus)
        );

        assign bus.inst_req   = r_inst_req;
        assign bus.inst_addr  = r_inst_addr;
        assign bus.data_req   = r_data_req;
        assign bus.data_addr  = r_data_addr;
        assign bus.data_wr_en = r_data_wr_en;
        assign bus.data_wr    = r_data_wr;
        assign bus.mem_rdata  = pipe[LAT-1];

        initial begin
            for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | i;
        end

        always @(posedge clk) begin
            if (bus.mem_en) begin
                pipe[0] <= ram[bus.mem_addr[9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wr_en[b])
                        ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        assign w_inst_gnt[g]    = bus.inst_gnt;
        assign w_data_gnt[g]    = bus.data_gnt;
        assign w_inst_rvalid[g] = bus.inst_rvalid;
        assign w_data_rvalid[g] = bus.data_rvalid;
        assign w_mem_en[g]      = bus.mem_en;
        assign w_mem_wr_en[g]   = bus.mem_wr_en;
        assign w_inst_rdata[g]  = bus.inst_rdata;
        assign w_data_rdata[g]  = bus.data_rdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r_inst_req   = 1'b0;
        r_inst_addr  = '0;
        r_data_req   = 1'b0;
        r_data_addr  = '0;
        r_data_wr_en = '0;
        r_data_wr    = '0;
    endtask

    // Requests are held high during reset (with a store pending) to show the
    // forcing of grants, mem_en and mem_wr_en.
    task automatic test_reset();
        r_rst        = 1'b1;
        r_inst_req   = 1'b1;
        r_inst_addr  = 32'h0;
        r_data_req   = 1'b1;
        r_data_addr  = 32'h100;
        r_data_wr_en = 4'hF;
        r_data_wr    = 32'h1234_5678;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if ((w_inst_gnt | w_data_gnt | w_mem_en | w_inst_rvalid | w_data_rvalid) !== 4'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d gnt_i=%b gnt_d=%b mem_en=%b rv_i=%b rv_d=%b required all 0",
                         n, w_inst_gnt, w_data_gnt, w_mem_en, w_inst_rvalid, w_data_rvalid);
            end
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (w_mem_wr_en[g] !== 4'b0) begin
                    failures++;
                    $display("FAIL reset_mem_wr_en lat=%0d got=%b required=0000", g + 1, w_mem_wr_en[g]);
                end
            end
            step();
        end
        idle_inputs();
        r_rst = 1'b0;
        #1;
        checks++;
        if ((w_inst_gnt | w_data_gnt | w_mem_en | w_inst_rvalid | w_data_rvalid) !== 4'b0) begin
            failures++;
            $display("FAIL post_reset_idle gnt_i=%b gnt_d=%b mem_en=%b rv_i=%b rv_d=%b required all 0",
                     w_inst_gnt, w_data_gnt, w_mem_en, w_inst_rvalid, w_data_rvalid);
        end
        step();
    endtask

    // Both ports request for 4 cycles straight out of reset: grants I,D,I,D;
    // responses in the same order RD_LAT cycles later (also the latency sweep).
    task automatic test_conflict();
        logic [31:0] exp_word [4];
        logic [31:0] inst_addr_seq [4];
        logic [31:0] data_addr_seq [4];
        logic exp_ig, exp_dg, exp_iv, exp_dv;
        int k;
        exp_word[0] = 32'hA000_0004;
        exp_word[1] = 32'hA000_0040;
        exp_word[2] = 32'hA000_0005;
        exp_word[3] = 32'hA000_0041;
        inst_addr_seq[0] = 32'h10;  data_addr_seq[0] = 32'h100;
        inst_addr_seq[1] = 32'h14;  data_addr_seq[1] = 32'h100;
        inst_addr_seq[2] = 32'h14;  data_addr_seq[2] = 32'h104;
        inst_addr_seq[3] = 32'h18;  data_addr_seq[3] = 32'h104;
        for (int n = 0; n < 9; n++) begin
            if (n < 4) begin
                r_inst_req   = 1'b1;
                r_inst_addr  = inst_addr_seq[n];
                r_data_req   = 1'b1;
                r_data_addr  = data_addr_seq[n];
                r_data_wr_en = 4'b0;
            end else begin
                idle_inputs();
            end
            #1;
            exp_ig = (n < 4) && (n % 2 == 0);
            exp_dg = (n < 4) && (n % 2 == 1);
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (w_inst_gnt[g] !== exp_ig || w_data_gnt[g] !== exp_dg) begin
                    failures++;
                    $display("FAIL conflict_grant lat=%0d cyc=%0d got I=%b D=%b required I=%b D=%b",
                             g + 1, n, w_inst_gnt[g], w_data_gnt[g], exp_ig, exp_dg);
                end
                k = n - (g + 1);
                exp_iv = (k == 0) || (k == 2);
                exp_dv = (k == 1) || (k == 3);
                checks++;
                if (w_inst_rvalid[g] !== exp_iv || w_data_rvalid[g] !== exp_dv) begin
                    failures++;
                    $display("FAIL conflict_rvalid lat=%0d cyc=%0d got I=%b D=%b required I=%b D=%b",
                             g + 1, n, w_inst_rvalid[g], w_data_rvalid[g], exp_iv, exp_dv);
                end
                if (exp_iv) begin
                    checks++;
                    if (w_inst_rdata[g] !== exp_word[k]) begin
                        failures++;
                        $display("FAIL conflict_inst_rdata lat=%0d cyc=%0d got=%h required=%h",
                                 g + 1, n, w_inst_rdata[g], exp_word[k]);
                    end
                end
                if (exp_dv) begin
                    checks++;
                    if (w_data_rdata[g] !== exp_word[k]) begin
                        failures++;
                        $display("FAIL conflict_data_rdata lat=%0d cyc=%0d got=%h required=%h",
                                 g + 1, n, w_data_rdata[g], exp_word[k]);
                    end
                end
            end
            step();
        end
    endtask

    // Fetches from 0x0, 0x4, 0x8 back to back.
    task automatic test_fetch_only();
        logic exp_iv;
        int k;
        for (int n = 0; n < 8; n++) begin
            idle_inputs();
            if (n < 3) begin
                r_inst_req  = 1'b1;
                r_inst_addr = 32'(4 * n);
            end
            #1;
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (w_inst_gnt[g] !== (n < 3) || w_data_gnt[g] !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_grant lat=%0d cyc=%0d got I=%b D=%b required I=%b D=0",
                             g + 1, n, w_inst_gnt[g], w_data_gnt[g], (n < 3));
                end
                k = n - (g + 1);
                exp_iv = (k >= 0) && (k < 3);
                checks++;
                if (w_inst_rvalid[g] !== exp_iv || w_data_rvalid[g] !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_rvalid lat=%0d cyc=%0d got I=%b D=%b required I=%b D=0",
                             g + 1, n, w_inst_rvalid[g], w_data_rvalid[g], exp_iv);
                end
                if (exp_iv) begin
                    checks++;
                    if (w_inst_rdata[g] !== (32'hA000_0000 | 32'(k))) begin
                        failures++;
                        $display("FAIL fetch_rdata lat=%0d cyc=%0d got=%h required=%h",
                                 g + 1, n, w_inst_rdata[g], 32'hA000_0000 | 32'(k));
                    end
                end
            end
            step();
        end
    endtask

    // Store to 0x40 then load it back.
    task automatic test_store_load(input string name, input logic [3:0] wen,
                                   input logic [31:0] wdata, input logic [31:0] exp_rd);
        logic [3:0] exp_wen;
        logic exp_dv;
        for (int n = 0; n < 8; n++) begin
            idle_inputs();
            if (n == 0) begin
                r_data_req   = 1'b1;
                r_data_addr  = 32'h40;
                r_data_wr_en = wen;
                r_data_wr    = wdata;
            end else if (n == 1) begin
                r_data_req   = 1'b1;
                r_data_addr  = 32'h40;
            end
            #1;
            exp_wen = (n == 0) ? wen : 4'b0;
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (w_data_gnt[g] !== (n < 2) || w_inst_gnt[g] !== 1'b0 || w_mem_en[g] !== (n < 2)) begin
                    failures++;
                    $display("FAIL %s_grant lat=%0d cyc=%0d got D=%b I=%b en=%b required D=%b I=0 en=%b",
                             name, g + 1, n, w_data_gnt[g], w_inst_gnt[g], w_mem_en[g], (n < 2), (n < 2));
                end
                checks++;
                if (w_mem_wr_en[g] !== exp_wen) begin
                    failures++;
                    $display("FAIL %s_mem_wr_en lat=%0d cyc=%0d got=%b required=%b",
                             name, g + 1, n, w_mem_wr_en[g], exp_wen);
                end
                exp_dv = (n == g + 2);
                checks++;
                if (w_data_rvalid[g] !== exp_dv || w_inst_rvalid[g] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_rvalid lat=%0d cyc=%0d got D=%b I=%b required D=%b I=0",
                             name, g + 1, n, w_data_rvalid[g], w_inst_rvalid[g], exp_dv);
                end
                if (exp_dv) begin
                    checks++;
                    if (w_data_rdata[g] !== exp_rd) begin
                        failures++;
                        $display("FAIL %s_rdata lat=%0d got=%h required=%h",
                                 name, g + 1, w_data_rdata[g], exp_rd);
                    end
                end
            end
            step();
        end
    endtask

    // A fetch is granted, reset hits one cycle later; its response must be
    // dropped and the first conflict after release goes to fetch.
    task automatic test_reset_in_flight();
        logic exp_iv, exp_dv;
        idle_inputs();
        r_inst_req  = 1'b1;
        r_inst_addr = 32'h0;
        #1;
        checks++;
        if (w_inst_gnt !== 4'b1111) begin
            failures++;
            $display("FAIL rif_fetch_grant got=%b required=1111", w_inst_gnt);
        end
        step();
        r_rst        = 1'b1;
        r_inst_req   = 1'b1;
        r_data_req   = 1'b1;
        r_data_addr  = 32'h100;
        r_data_wr_en = 4'hF;
        r_data_wr    = 32'hFFFF_FFFF;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if ((w_inst_gnt | w_data_gnt | w_mem_en | w_inst_rvalid | w_data_rvalid) !== 4'b0) begin
                failures++;
                $display("FAIL rif_in_reset cyc=%0d gnt_i=%b gnt_d=%b mem_en=%b rv_i=%b rv_d=%b required all 0",
                         n, w_inst_gnt, w_data_gnt, w_mem_en, w_inst_rvalid, w_data_rvalid);
            end
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (w_mem_wr_en[g] !== 4'b0) begin
                    failures++;
                    $display("FAIL rif_mem_wr_en lat=%0d got=%b required=0000", g + 1, w_mem_wr_en[g]);
                end
            end
            step();
        end
        r_rst        = 1'b0;
        r_data_wr_en = 4'b0;
        for (int n = 0; n < 7; n++) begin
            if (n == 1) r_inst_req = 1'b0;
            if (n == 2) idle_inputs();
            #1;
            for (int g = 0; g < 4; g++) begin
                if (n < 2) begin
                    checks++;
                    if (w_inst_gnt[g] !== (n == 0) || w_data_gnt[g] !== (n == 1)) begin
                        failures++;
                        $display("FAIL rif_post_grant lat=%0d cyc=%0d got I=%b D=%b required I=%b D=%b",
                                 g + 1, n, w_inst_gnt[g], w_data_gnt[g], (n == 0), (n == 1));
                    end
                end
                exp_iv = (n == g + 1);
                exp_dv = (n == g + 2);
                checks++;
                if (w_inst_rvalid[g] !== exp_iv || w_data_rvalid[g] !== exp_dv) begin
                    failures++;
                    $display("FAIL rif_post_rvalid lat=%0d cyc=%0d got I=%b D=%b required I=%b D=%b",
                             g + 1, n, w_inst_rvalid[g], w_data_rvalid[g], exp_iv, exp_dv);
                end
                if (exp_iv) begin
                    checks++;
                    if (w_inst_rdata[g] !== 32'hA000_0000) begin
                        failures++;
                        $display("FAIL rif_inst_rdata lat=%0d got=%h required=a0000000", g + 1, w_inst_rdata[g]);
                    end
                end
                if (exp_dv) begin
                    checks++;
                    if (w_data_rdata[g] !== 32'hA000_0040) begin
                        failures++;
                        $display("FAIL rif_data_rdata lat=%0d got=%h required=a0000040", g + 1, w_data_rdata[g]);
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        r_rst = 1'b1;
        step();
        test_reset();
        test_conflict();
        test_fetch_only();
        test_store_load("store_load", 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_store_load("byte_store", 4'b0001, 32'h0000_00AA, 32'hDEAD_BEAA);
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
